// File: rtl/axi_tdd_sync_monitor.sv
// Receive-side TDD sync monitor: measures sync intervals against period/tolerance,
// tracks lock, counts timing errors and forwards only qualified sync pulses.
module axi_tdd_sync_monitor #(
    parameter int unsigned SYNC_COUNT_WIDTH  = 64,
    parameter int unsigned SYNC_EXTERNAL_CDC = 0,
    parameter int unsigned LOCK_COUNT        = 4,
    parameter int unsigned LOSS_COUNT        = 2,
    parameter int unsigned ERR_COUNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sync_in,
    input  logic                        tdd_enable,
    input  logic [SYNC_COUNT_WIDTH-1:0] asy_tdd_sync_period,
    input  logic [SYNC_COUNT_WIDTH-1:0] asy_tdd_sync_tolerance,
    input  logic                        err_clear,
    output logic                        sync_out,
    output logic                        sync_locked,
    output logic                        sync_early,
    output logic                        sync_missing,
    output logic [SYNC_COUNT_WIDTH-1:0] sync_interval,
    output logic [ERR_COUNT_WIDTH-1:0]  sync_err_count
);

    localparam int unsigned CW = SYNC_COUNT_WIDTH;
    localparam int unsigned HW = SYNC_COUNT_WIDTH + 1;
    localparam int unsigned EW = ERR_COUNT_WIDTH;
    localparam int unsigned QW = 8;
    localparam logic [QW-1:0] LOCK_N = QW'(LOCK_COUNT);
    localparam logic [QW-1:0] LOSS_N = QW'(LOSS_COUNT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_TRACK  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   period_q, tol_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [QW-1:0]   good_q, good_d;
    logic [QW-1:0]   bad_q, bad_d;
    logic            sync_out_q, sync_out_d;
    logic            locked_q, locked_d;
    logic            early_q, early_d;
    logic            missing_q, missing_d;
    logic [CW-1:0]   interval_q, interval_d;
    logic [EW-1:0]   err_q, err_d;

    logic            evt_c;
    logic [CW-1:0]   lo_c;
    logic [HW-1:0]   hi_c;
    logic [HW-1:0]   cnt_p1_c;
    logic [CW-1:0]   cnt_inc_c;
    logic            active_c;
    logic            missing_c;
    logic            early_c;
    logic            good_c;
    logic            err_inc_c;

    // Event source: edge-detected 3-flop synchronizer, or a clk-synchronous pulse
    generate
        if (SYNC_EXTERNAL_CDC != 0) begin : g_cdc
            logic [2:0] meta_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_q <= '0;
                end else begin
                    meta_q <= {meta_q[1:0], sync_in};
                end
            end
            assign evt_c = meta_q[1] & ~meta_q[2];
        end else begin : g_sync
            assign evt_c = sync_in;
        end
    endgenerate

    // Period and tolerance follow the asy_ inputs only while enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            tol_q    <= '0;
        end else if (tdd_enable) begin
            period_q <= asy_tdd_sync_period;
            tol_q    <= asy_tdd_sync_tolerance;
        end
    end

    // Window bounds and interval classification
    always_comb begin
        lo_c      = (period_q > tol_q) ? (period_q - tol_q) : '0;
        hi_c      = HW'(period_q) + HW'(tol_q);
        cnt_p1_c  = HW'(cnt_q) + HW'(1);
        cnt_inc_c = (&cnt_q) ? cnt_q : (cnt_q + CW'(1));
        active_c  = tdd_enable && (period_q != '0) &&
                    ((state_q == S_TRACK) || (state_q == S_LOCKED));
        // A late event coinciding with the timeout is one missing error only
        missing_c = active_c && (cnt_p1_c > hi_c);
        early_c   = active_c && evt_c && !missing_c && (cnt_p1_c < HW'(lo_c));
        good_c    = active_c && evt_c && !missing_c && !early_c;
        err_inc_c = early_c | missing_c;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc_c;
        good_d     = good_q;
        bad_d      = bad_q;
        sync_out_d = 1'b0;
        early_d    = early_c;
        missing_d  = missing_c;
        interval_d = interval_q;
        err_d      = err_q;

        if (tdd_enable && evt_c && (state_q != S_IDLE)) begin
            interval_d = cnt_inc_c;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                good_d = '0;
                bad_d  = '0;
                state_d = S_ACQ;
            end
            S_ACQ: begin
                if (evt_c) begin
                    cnt_d   = '0;
                    good_d  = '0;
                    bad_d   = '0;
                    state_d = S_TRACK;
                end
            end
            S_TRACK: begin
                if (evt_c || missing_c) begin
                    cnt_d = '0;
                end
                if (good_c) begin
                    good_d = good_q + QW'(1);
                    bad_d  = '0;
                    if ((good_q + QW'(1)) == LOCK_N) begin
                        state_d    = S_LOCKED;
                        sync_out_d = 1'b1;
                    end
                end else if (err_inc_c) begin
                    good_d = '0;
                end
            end
            S_LOCKED: begin
                if (evt_c || missing_c) begin
                    cnt_d = '0;
                end
                if (period_q == '0) begin
                    state_d = S_TRACK;
                    good_d  = '0;
                    bad_d   = '0;
                end else if (good_c) begin
                    bad_d      = '0;
                    sync_out_d = 1'b1;
                end else if (err_inc_c) begin
                    if ((bad_q + QW'(1)) == LOSS_N) begin
                        state_d = S_TRACK;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + QW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!tdd_enable) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            good_d     = '0;
            bad_d      = '0;
            sync_out_d = 1'b0;
        end

        // Clear wins, but an error landing on the clear cycle still counts
        if (err_clear) begin
            err_d = EW'(err_inc_c);
        end else if (err_inc_c && !(&err_q)) begin
            err_d = err_q + EW'(1);
        end

        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            sync_out_q <= 1'b0;
            locked_q   <= 1'b0;
            early_q    <= 1'b0;
            missing_q  <= 1'b0;
            interval_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            sync_out_q <= sync_out_d;
            locked_q   <= locked_d;
            early_q    <= early_d;
            missing_q  <= missing_d;
            interval_q <= interval_d;
            err_q      <= err_d;
        end
    end

    assign sync_out       = sync_out_q;
    assign sync_locked    = locked_q;
    assign sync_early     = early_q;
    assign sync_missing   = missing_q;
    assign sync_interval  = interval_q;
    assign sync_err_count = err_q;

endmodule

// File: tb/tb_axi_tdd_sync_monitor.sv
// Directed bench for axi_tdd_sync_monitor: lock/unlock, early/missing, bounds,
// period zero, error counter saturation/clear, disable/reset and the CDC path.
module tb_axi_tdd_sync_monitor;

    localparam int unsigned CW = 16;
    localparam int unsigned EW = 4;

    logic          clk;
    logic          rst;
    logic          sync_in;
    logic          sync_in_a;
    logic          tdd_enable;
    logic          err_clear;
    logic [CW-1:0] period;
    logic [CW-1:0] tol;

    logic          so, lk, ea, mi;
    logic [CW-1:0] iv;
    logic [EW-1:0] ec;
    logic          so_a, lk_a, ea_a, mi_a;
    logic [CW-1:0] iv_a;
    logic [EW-1:0] ec_a;

    int total;
    int bad;

    axi_tdd_sync_monitor #(
        .SYNC_COUNT_WIDTH(CW), .SYNC_EXTERNAL_CDC(0), .LOCK_COUNT(4),
        .LOSS_COUNT(2), .ERR_COUNT_WIDTH(EW)
    ) dut (
        .clk(clk), .rst(rst), .sync_in(sync_in), .tdd_enable(tdd_enable),
        .asy_tdd_sync_period(period), .asy_tdd_sync_tolerance(tol),
        .err_clear(err_clear), .sync_out(so), .sync_locked(lk),
        .sync_early(ea), .sync_missing(mi), .sync_interval(iv),
        .sync_err_count(ec)
    );

    axi_tdd_sync_monitor #(
        .SYNC_COUNT_WIDTH(CW), .SYNC_EXTERNAL_CDC(1), .LOCK_COUNT(4),
        .LOSS_COUNT(2), .ERR_COUNT_WIDTH(EW)
    ) dut_cdc (
        .clk(clk), .rst(rst), .sync_in(sync_in_a), .tdd_enable(tdd_enable),
        .asy_tdd_sync_period(period), .asy_tdd_sync_tolerance(tol),
        .err_clear(err_clear), .sync_out(so_a), .sync_locked(lk_a),
        .sync_early(ea_a), .sync_missing(mi_a), .sync_interval(iv_a),
        .sync_err_count(ec_a)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pulse;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
    endtask

    // Event exactly n cycles after the previous one
    task automatic gap_pulse(input int n);
        repeat (n - 1) tick();
        send_pulse();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({so, lk, ea, mi} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {so, lk, ea, mi});
        end
        total++;
        if (iv !== '0 || ec !== '0) begin
            bad++; $display("FAIL reset_counts: got iv=%0d ec=%0d want 0 0", iv, ec);
        end
        rst = 1'b0;
    endtask

    task automatic test_lock;
        period = CW'(10);
        tol = CW'(1);
        tdd_enable = 1'b1;
        tick();
        send_pulse();
        total++;
        if (iv !== CW'(1) || lk !== 1'b0 || ea !== 1'b0) begin
            bad++; $display("FAIL acq_event: got iv=%0d lk=%0d ea=%0d want 1 0 0", iv, lk, ea);
        end
        for (int i = 0; i < 4; i++) begin
            gap_pulse(10);
            total++;
            if (lk !== (i == 3) || so !== (i == 3) || iv !== CW'(10)) begin
                bad++;
                $display("FAIL lock_seq%0d: got lk=%0d so=%0d iv=%0d want %0d %0d 10",
                         i, lk, so, iv, (i == 3), (i == 3));
            end
        end
        tick();
        total++;
        if (so !== 1'b0 || lk !== 1'b1 || ec !== '0) begin
            bad++; $display("FAIL lock_hold: got so=%0d lk=%0d ec=%0d want 0 1 0", so, lk, ec);
        end
    endtask

    task automatic test_early;
        // Re-align: last event was 1 cycle ago, so an 8-gap here is a 9-cycle interval... keep exact
        gap_pulse(9);
        total++;
        if (so !== 1'b1 || iv !== CW'(10)) begin
            bad++; $display("FAIL realign: got so=%0d iv=%0d want 1 10", so, iv);
        end
        gap_pulse(7);
        total++;
        if (ea !== 1'b1 || ec !== EW'(1) || lk !== 1'b1 || so !== 1'b0 || iv !== CW'(7)) begin
            bad++; $display("FAIL early1: got ea=%0d ec=%0d lk=%0d so=%0d iv=%0d want 1 1 1 0 7",
                            ea, ec, lk, so, iv);
        end
        gap_pulse(10);
        total++;
        if (ea !== 1'b0 || so !== 1'b1 || lk !== 1'b1) begin
            bad++; $display("FAIL early_recover: got ea=%0d so=%0d lk=%0d want 0 1 1", ea, so, lk);
        end
        gap_pulse(7);
        total++;
        if (ea !== 1'b1 || ec !== EW'(2) || lk !== 1'b1) begin
            bad++; $display("FAIL early2: got ea=%0d ec=%0d lk=%0d want 1 2 1", ea, ec, lk);
        end
        gap_pulse(10);
    endtask

    task automatic test_missing;
        repeat (11) tick();
        total++;
        if (mi !== 1'b0) begin
            bad++; $display("FAIL miss_before: got %0d want 0", mi);
        end
        tick();
        total++;
        if (mi !== 1'b1 || lk !== 1'b1 || ec !== EW'(3)) begin
            bad++; $display("FAIL miss1: got mi=%0d lk=%0d ec=%0d want 1 1 3", mi, lk, ec);
        end
        repeat (11) tick();
        total++;
        if (mi !== 1'b0 || lk !== 1'b1) begin
            bad++; $display("FAIL miss_gap: got mi=%0d lk=%0d want 0 1", mi, lk);
        end
        tick();
        total++;
        if (mi !== 1'b1 || lk !== 1'b0 || ec !== EW'(4)) begin
            bad++; $display("FAIL miss2: got mi=%0d lk=%0d ec=%0d want 1 0 4", mi, lk, ec);
        end
    endtask

    task automatic test_late_boundary;
        gap_pulse(12);
        total++;
        if (mi !== 1'b1 || ea !== 1'b0 || ec !== EW'(5) || iv !== CW'(12)) begin
            bad++; $display("FAIL late12: got mi=%0d ea=%0d ec=%0d iv=%0d want 1 0 5 12",
                            mi, ea, ec, iv);
        end
        gap_pulse(9);
        total++;
        if (mi !== 1'b0 || ea !== 1'b0 || ec !== EW'(5) || iv !== CW'(9)) begin
            bad++; $display("FAIL edge9: got mi=%0d ea=%0d ec=%0d iv=%0d want 0 0 5 9", mi, ea, ec, iv);
        end
        gap_pulse(11);
        total++;
        if (mi !== 1'b0 || ea !== 1'b0 || ec !== EW'(5) || iv !== CW'(11)) begin
            bad++; $display("FAIL edge11: got mi=%0d ea=%0d ec=%0d iv=%0d want 0 0 5 11", mi, ea, ec, iv);
        end
        gap_pulse(10);
        total++;
        if (lk !== 1'b0) begin
            bad++; $display("FAIL relock_early: got lk=%0d want 0", lk);
        end
        gap_pulse(10);
        total++;
        if (lk !== 1'b1 || so !== 1'b1) begin
            bad++; $display("FAIL relock: got lk=%0d so=%0d want 1 1", lk, so);
        end
    endtask

    task automatic test_err_sat_clear;
        sync_in = 1'b1;
        repeat (20) tick();
        total++;
        if (ec !== EW'(15) || ea !== 1'b1 || lk !== 1'b0) begin
            bad++; $display("FAIL err_sat: got ec=%0d ea=%0d lk=%0d want 15 1 0", ec, ea, lk);
        end
        tick();
        total++;
        if (ec !== EW'(15)) begin
            bad++; $display("FAIL err_hold: got %0d want 15", ec);
        end
        err_clear = 1'b1;
        tick();
        total++;
        if (ec !== EW'(1) || ea !== 1'b1) begin
            bad++; $display("FAIL err_clear_hit: got ec=%0d ea=%0d want 1 1", ec, ea);
        end
        sync_in = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic test_wide_tolerance;
        period = CW'(3);
        tol = CW'(5);
        tick();
        sync_in = 1'b1;
        repeat (3) tick();
        total++;
        if (lk !== 1'b0 || ea !== 1'b0) begin
            bad++; $display("FAIL tol_pre: got lk=%0d ea=%0d want 0 0", lk, ea);
        end
        tick();
        sync_in = 1'b0;
        total++;
        if (lk !== 1'b1 || so !== 1'b1 || iv !== CW'(1) || ec !== EW'(1) || ea !== 1'b0) begin
            bad++; $display("FAIL tol_lock: got lk=%0d so=%0d iv=%0d ec=%0d ea=%0d want 1 1 1 1 0",
                            lk, so, iv, ec, ea);
        end
    endtask

    task automatic test_period_zero;
        period = '0;
        tol = '0;
        gap_pulse(5);
        total++;
        if ({lk, so, ea, mi} !== 4'b0000 || iv !== CW'(5) || ec !== EW'(1)) begin
            bad++; $display("FAIL p0_a: got flags=%b iv=%0d ec=%0d want 0000 5 1", {lk, so, ea, mi}, iv, ec);
        end
        gap_pulse(20);
        total++;
        if ({lk, so, ea, mi} !== 4'b0000 || iv !== CW'(20) || ec !== EW'(1)) begin
            bad++; $display("FAIL p0_b: got flags=%b iv=%0d ec=%0d want 0000 20 1", {lk, so, ea, mi}, iv, ec);
        end
    endtask

    task automatic test_disable_reset;
        period = CW'(10);
        tol = CW'(1);
        repeat (4) gap_pulse(10);
        total++;
        if (lk !== 1'b1) begin
            bad++; $display("FAIL dis_prelock: got %0d want 1", lk);
        end
        tdd_enable = 1'b0;
        tick();
        total++;
        if ({lk, so, ea, mi} !== 4'b0000) begin
            bad++; $display("FAIL disable: got %b want 0000", {lk, so, ea, mi});
        end
        tdd_enable = 1'b1;
        tick();
        send_pulse();
        total++;
        if (ea !== 1'b0 || ec !== EW'(1) || iv !== CW'(1) || lk !== 1'b0) begin
            bad++; $display("FAIL reacq: got ea=%0d ec=%0d iv=%0d lk=%0d want 0 1 1 0", ea, ec, iv, lk);
        end
        repeat (4) gap_pulse(10);
        rst = 1'b1;
        tick();
        total++;
        if ({lk, so, ea, mi} !== 4'b0000 || iv !== '0 || ec !== '0) begin
            bad++; $display("FAIL mid_reset: got flags=%b iv=%0d ec=%0d want 0000 0 0", {lk, so, ea, mi}, iv, ec);
        end
        rst = 1'b0;
    endtask

    task automatic test_cdc;
        tick();
        for (int i = 0; i < 5; i++) begin
            #3 sync_in_a = 1'b1;
            tick();
            tick();
            total++;
            if (so_a !== 1'b0 || lk_a !== 1'b0) begin
                bad++; $display("FAIL cdc_lat%0d: got so=%0d lk=%0d want 0 0", i, so_a, lk_a);
            end
            tick();
            sync_in_a = 1'b0;
            total++;
            if (so_a !== (i == 4) || lk_a !== (i == 4) || (i > 0 && iv_a !== CW'(10))) begin
                bad++; $display("FAIL cdc_evt%0d: got so=%0d lk=%0d iv=%0d want %0d %0d 10",
                                i, so_a, lk_a, iv_a, (i == 4), (i == 4));
            end
            repeat (7) tick();
        end
        total++;
        if (ec_a !== '0 || ea_a !== 1'b0 || mi_a !== 1'b0) begin
            bad++; $display("FAIL cdc_err: got ec=%0d ea=%0d mi=%0d want 0 0 0", ec_a, ea_a, mi_a);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        sync_in = 1'b0;
        sync_in_a = 1'b0;
        tdd_enable = 1'b0;
        err_clear = 1'b0;
        period = '0;
        tol = '0;
        test_reset();
        test_lock();
        test_early();
        test_missing();
        test_late_boundary();
        test_err_sat_clear();
        test_wide_tolerance();
        test_period_zero();
        test_disable_reset();
        test_cdc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_tdd_sync_monitor.md
Name: axi_tdd_sync_monitor

Overview:
Receive-side counterpart of the TDD sync generator. It consumes the sync pulse train arriving at a TDD slave, measures the interval between pulses and checks each interval against the programmed period and tolerance. It declares lock or loss of lock, counts timing errors, and re-issues only qualified sync pulses to the local TDD timing core.

Parameters:
SYNC_COUNT_WIDTH, 64, width of the period, tolerance, interval counter and measured interval
SYNC_EXTERNAL_CDC, 0, 1 = sync_in is asynchronous (3-flop synchronizer + rising-edge detect); 0 = sync_in is a clk-synchronous single-cycle pulse
LOCK_COUNT, 4, consecutive good intervals needed to assert lock (range 1..255)
LOSS_COUNT, 2, consecutive bad events needed to drop lock (range 1..255)
ERR_COUNT_WIDTH, 16, width of the error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sync_in  in  1  incoming sync
tdd_enable  in  1  monitor enable
asy_tdd_sync_period  in  SYNC_COUNT_WIDTH  expected interval in cycles; quasi-static
asy_tdd_sync_tolerance  in  SYNC_COUNT_WIDTH  allowed deviation in cycles; quasi-static
err_clear  in  1  clears the error counter
sync_out  out  1  qualified sync pulse, 1 cycle
sync_locked  out  1  lock status
sync_early  out  1  1-cycle pulse on an early event
sync_missing  out  1  1-cycle pulse on a timeout or late event
sync_interval  out  SYNC_COUNT_WIDTH  last measured interval
sync_err_count  out  ERR_COUNT_WIDTH  saturating error count

Behaviour:
- Reset and enable: clk is the only clock; rst is synchronous and active-high. While rst=1, all outputs, counters, synchronizer flops and the FSM are cleared (FSM to IDLE). Reset asserted mid-operation takes effect on the next edge.
- Configuration: period P and tolerance T are registered from the asy_ inputs every cycle while tdd_enable=1 and held while tdd_enable=0.
- Event detection:
  - CDC=1: event = m2 & ~m3 (3-flop chain); latency 2 cycles from the sync_in rise.
  - CDC=0: event = sync_in.
- Bounds:
  - lo = P - T, saturating at 0.
  - hi = P + T, computed in SYNC_COUNT_WIDTH+1 bits.
- Interval counter cnt:
  - Cleared to 0 on an event or a timeout; otherwise increments and saturates at all-ones.
  - Interval N = cnt + 1 on the event cycle. Events at cycles t and t+N give N.
- Classification, evaluated in TRACK and LOCKED only:
  - good: lo <= N <= hi.
  - early: N < lo. Pulse sync_early.
  - timeout: cnt + 1 > hi with no event. Pulse sync_missing. An event arriving on that same cycle is also classified as a single missing error, never two errors.
  - early and missing each increment sync_err_count by 1.
- Period zero: if P = 0, no classification, no errors and no lock. sync_interval still updates and the FSM stays in TRACK.
- FSM:
  - IDLE: entered whenever tdd_enable=0. Clears cnt, good/bad counters and sync_locked. Goes to ACQ when tdd_enable=1.
  - ACQ: the first event is not classified. cnt is cleared and the FSM goes to TRACK.
  - TRACK: a good event increments good_cnt and clears bad_cnt. A bad event clears good_cnt. When good_cnt reaches LOCK_COUNT, go to LOCKED.
  - LOCKED: a good event clears bad_cnt. A bad event increments bad_cnt. When bad_cnt reaches LOSS_COUNT, go to TRACK and clear good_cnt.
- sync_locked is 1 exactly while in LOCKED; it is registered and asserts the cycle after the qualifying event.
- sync_out is a registered pulse, 1 cycle after each good event while in LOCKED. This includes the event that causes the TRACK-to-LOCKED transition.
- sync_interval updates 1 cycle after every event, including the ACQ event.
- Error counter:
  - Saturates at all-ones.
  - err_clear has priority: on the clear cycle the count is 0, plus 1 if an error occurs in that same cycle.

Test Plan:
- P=10, T=1, LOCK_COUNT=4, CDC=0, pulses every 10 cycles -> sync_locked rises 1 cycle after the 5th pulse (ACQ + 4 good); sync_out pulses on the 5th pulse onward; sync_interval=10; sync_err_count=0.
- Locked, then one pulse at interval 7 (< lo=9) -> sync_early pulse, err=1, still locked; next interval 10 clears bad_cnt; a second early interval later still does not unlock.
- Locked, then pulses stop -> sync_missing every 12 cycles (cnt+1 = 12 > hi = 11); after 2 timeouts sync_locked=0; err=2.
- Pulse arriving exactly at interval 12 -> exactly one sync_missing, err +1, no sync_early; intervals 9 and 11 are good.
- P=3, T=5 (lo saturates at 0) -> an interval of 1 is good; P=0 -> no errors, no lock, sync_interval still tracks.
- CDC=1 with an asynchronous 3-cycle-wide sync_in -> one event per rise, 2-cycle latency. Error counter at all-ones stays saturated. err_clear coincident with an error -> count=1. rst or tdd_enable=0 mid-lock -> all outputs 0 and FSM in IDLE next cycle.
